nes_joypad_port: RTL and testbench

- Downstream of wiicontroller: turns its decoded Classic Controller button vectors into an NES standard-controller serial port, as seen by the CPU at $4016.
- Snapshots buttons on strobe and shifts them out one bit per CPU read, in NES order.
- Filters impossible D-pad combinations.
- Exposes the latched byte and the read count so the top level can show them on LEDs.

---
 rtl/nes_joypad_port.sv | 126 ++++++++++++
 tb/tb_nes_joypad_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_port.sv
// NES $4016 serial joypad port driven by decoded Classic Controller buttons.
// Define TURBO_EN to let ZL/ZR force A/B to a free-running turbo square wave.
//
// state    | meaning
// ST_SHIFT | strobe low: each read shifts the snapshot out LSB first, 1s fill in
// ST_LOAD  | strobe high: snapshot, latched byte and read count follow live buttons
module nes_joypad_port #(
    parameter logic [6:0]  OPEN_BUS_VAL = 7'h20,
    parameter bit          MAP_XY       = 1'b1,
    parameter bit          SOCD_FILTER  = 1'b1,
    parameter int unsigned TURBO_HALF   = 1666667
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] udlr_dpad,
    input  logic [3:0] abxy_btns,
    input  logic [2:0] st_sel_hm_btns,
    input  logic [1:0] lr_z_btns,
    input  logic       strobe_we,
    input  logic       strobe_wd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic [7:0] latched_btns,
    output logic [3:0] bits_read
);

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_LOAD  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] latched_q, latched_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] live;
    logic       up, dn, lf, rt, btn_a, btn_b;

    logic unused_home;
    assign unused_home = st_sel_hm_btns[0];

`ifdef TURBO_EN
    logic [20:0] turbo_cnt_q;
    logic        turbo_phase_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else if (turbo_cnt_q == 21'(TURBO_HALF - 1)) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= ~turbo_phase_q;
        end else begin
            turbo_cnt_q   <= turbo_cnt_q + 21'd1;
        end
    end
`else
    logic unused_turbo;
    assign unused_turbo = ^lr_z_btns;
`endif

    always_comb begin
        up = udlr_dpad[3];
        dn = udlr_dpad[2];
        lf = udlr_dpad[1];
        rt = udlr_dpad[0];
        // A real NES pad cannot report opposing directions; games can glitch on them.
        if (SOCD_FILTER && up && dn) begin
            up = 1'b0;
            dn = 1'b0;
        end
        if (SOCD_FILTER && lf && rt) begin
            lf = 1'b0;
            rt = 1'b0;
        end
        btn_a = abxy_btns[3] | (MAP_XY & abxy_btns[1]);
        btn_b = abxy_btns[2] | (MAP_XY & abxy_btns[0]);
`ifdef TURBO_EN
        if (lr_z_btns[1]) btn_a = turbo_phase_q;
        if (lr_z_btns[0]) btn_b = turbo_phase_q;
`endif
        live = {rt, lf, dn, up, st_sel_hm_btns[2], st_sel_hm_btns[1], btn_b, btn_a};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        latched_d = latched_q;
        cnt_d     = cnt_q;
        if (strobe_we) state_d = strobe_wd ? ST_LOAD : ST_SHIFT;
        case (state_q)
            ST_LOAD: begin
                shift_d   = live;
                latched_d = live;
                cnt_d     = 4'd0;
            end
            ST_SHIFT: begin
                if (rd_en) begin
                    shift_d = {1'b1, shift_q[7:1]};
                    if (cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SHIFT;
            shift_q   <= 8'h00;
            latched_q <= 8'h00;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            latched_q <= latched_d;
            cnt_q     <= cnt_d;
        end
    end

    // The CPU samples in the rd_en cycle, so the serial bit must be combinational.
    assign rd_data      = {OPEN_BUS_VAL, (state_q == ST_LOAD) ? live[0] : shift_q[0]};
    assign latched_btns = latched_q;
    assign bits_read    = cnt_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port: directed hazards plus randomized
// strobe/read sequences against a snapshot-and-index reference model.
module tb_nes_joypad_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] udlr_dpad, abxy_btns;
    logic [2:0] st_sel_hm_btns;
    logic [1:0] lr_z_btns;
    logic       strobe_we, strobe_wd, rd_en;
    logic [7:0] rd_data, latched_btns, rd_data_alt, latched_alt;
    logic [3:0] bits_read, bits_read_alt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nes_joypad_port #(.TURBO_HALF(4)) u_dut (
        .clk(clk), .reset(reset), .udlr_dpad(udlr_dpad), .abxy_btns(abxy_btns),
        .st_sel_hm_btns(st_sel_hm_btns), .lr_z_btns(lr_z_btns),
        .strobe_we(strobe_we), .strobe_wd(strobe_wd), .rd_en(rd_en),
        .rd_data(rd_data), .latched_btns(latched_btns), .bits_read(bits_read)
    );

    nes_joypad_port #(.MAP_XY(1'b0), .SOCD_FILTER(1'b0), .TURBO_HALF(4)) u_alt (
        .clk(clk), .reset(reset), .udlr_dpad(udlr_dpad), .abxy_btns(abxy_btns),
        .st_sel_hm_btns(st_sel_hm_btns), .lr_z_btns(lr_z_btns),
        .strobe_we(strobe_we), .strobe_wd(strobe_wd), .rd_en(rd_en),
        .rd_data(rd_data_alt), .latched_btns(latched_alt), .bits_read(bits_read_alt)
    );

    // NES byte a pad would report for the given Wii buttons.
    function automatic logic [7:0] nes_byte(input logic [3:0] dp, input logic [3:0] ab,
                                            input logic [2:0] ss, input bit map_xy, input bit socd);
        logic [7:0] b;
        bit ud_clash, lr_clash;
        ud_clash = socd && dp[3] && dp[2];
        lr_clash = socd && dp[1] && dp[0];
        b[0] = ab[3] || (map_xy && ab[1]);
        b[1] = ab[2] || (map_xy && ab[0]);
        b[2] = ss[1];
        b[3] = ss[2];
        b[4] = dp[3] && !ud_clash;
        b[5] = dp[2] && !ud_clash;
        b[6] = dp[1] && !lr_clash;
        b[7] = dp[0] && !lr_clash;
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_strobe(input logic v);
        strobe_we = 1'b1;
        strobe_wd = v;
        tick();
        strobe_we = 1'b0;
    endtask

    task automatic rand_btns;
        udlr_dpad      = 4'($urandom);
        abxy_btns      = 4'($urandom);
        st_sel_hm_btns = 3'($urandom);
`ifdef TURBO_EN
        lr_z_btns      = 2'b00;
`else
        lr_z_btns      = 2'($urandom);
`endif
    endtask

    // Read one bit and compare both instances against their snapshots.
    task automatic read_bit(input string tag, input logic [7:0] snap, input logic [7:0] snap_alt,
                            input int idx);
        logic eb, eb_alt;
        eb     = (idx < 8) ? snap[idx % 8] : 1'b1;
        eb_alt = (idx < 8) ? snap_alt[idx % 8] : 1'b1;
        rd_en = 1'b1;
        #2;
        check_eq({tag, "_bit"}, rd_data[0], eb);
        check_eq({tag, "_bit_alt"}, rd_data_alt[0], eb_alt);
        check_eq({tag, "_openbus"}, rd_data[7:1], 7'h20);
        tick();
        rd_en = 1'b0;
    endtask

    logic [7:0] snap, snap_alt, lv, lv_alt;
    logic       s_turbo [24];
    int         first;

    initial begin
        reset = 1'b0;
        udlr_dpad = 4'h0; abxy_btns = 4'b1000; st_sel_hm_btns = 3'b000; lr_z_btns = 2'b00;
        strobe_we = 1'b0; strobe_wd = 1'b0; rd_en = 1'b0;
        #2;
        check_eq("reset_rd_data", rd_data, 8'h40);
        check_eq("reset_latched", latched_btns, 8'h00);
        check_eq("reset_bits_read", bits_read, 4'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // A + Start, 10 reads
        abxy_btns = 4'b1000; st_sel_hm_btns = 3'b100;
        wr_strobe(1'b1);
        wr_strobe(1'b0);
        check_eq("t1_latched", latched_btns, 8'h09);
        check_eq("t1_latched_alt", latched_alt, 8'h09);
        for (int i = 0; i < 10; i++) read_bit("t1_read", 8'h09, 8'h09, i);
        check_eq("t1_bits_read", bits_read, 4'd8);

        // strobe held high: A visible with zero latency
        abxy_btns = 4'h0; st_sel_hm_btns = 3'b000;
        wr_strobe(1'b1);
        for (int i = 0; i < 20; i++) begin
            abxy_btns = ((i / 5) % 2 == 1) ? 4'b1000 : 4'b0000;
            rd_en = 1'b1;
            #2;
            check_eq("t2_live_a", rd_data[0], 32'((i / 5) % 2));
            tick();
            rd_en = 1'b0;
            check_eq("t2_bits_read", bits_read, 4'd0);
        end
        abxy_btns = 4'b0000;
        wr_strobe(1'b0);
        abxy_btns = 4'b1000;
        read_bit("t2_first_after_fall", 8'h00, 8'h00, 0);

        // SOCD: up+down+left
        udlr_dpad = 4'b1110; abxy_btns = 4'h0;
        wr_strobe(1'b1);
        wr_strobe(1'b0);
        check_eq("t3_latched", latched_btns, 8'h40);
        check_eq("t3_latched_alt", latched_alt, 8'h70);
        for (int i = 0; i < 8; i++) read_bit("t3_read", 8'h40, 8'h70, i);

        // Y only
        udlr_dpad = 4'h0; abxy_btns = 4'b0001;
        wr_strobe(1'b1);
        wr_strobe(1'b0);
        check_eq("t4_latched", latched_btns, 8'h02);
        check_eq("t4_latched_alt", latched_alt, 8'h00);
        for (int i = 0; i < 3; i++) read_bit("t4_read", 8'h02, 8'h00, i);

        // read coincident with strobe write, then async reset mid-sequence
        abxy_btns = 4'b1000; st_sel_hm_btns = 3'b100;
        wr_strobe(1'b1);
        wr_strobe(1'b0);
        for (int i = 0; i < 3; i++) read_bit("t5_pre", 8'h09, 8'h09, i);
        rd_en = 1'b1; strobe_we = 1'b1; strobe_wd = 1'b1;
        #2;
        check_eq("t5_coincident_bit", rd_data[0], 1'b1);
        tick();
        rd_en = 1'b0; strobe_we = 1'b0;
        tick();
        check_eq("t5_bits_after_reload", bits_read, 4'd0);
        wr_strobe(1'b0);
        for (int i = 0; i < 2; i++) read_bit("t5_pre_reset", 8'h09, 8'h09, i);
        #1 reset = 1'b0;
        #1;
        check_eq("t5_reset_rd_data", rd_data, 8'h40);
        check_eq("t5_reset_latched", latched_btns, 8'h00);
        check_eq("t5_reset_bits", bits_read, 4'd0);
        check_eq("t5_reset_rd_data_alt", rd_data_alt, 8'h40);
        tick();
        reset = 1'b1;
        rd_en = 1'b1;
        #2;
        check_eq("t5_read_after_reset", rd_data, 8'h40);
        tick();
        rd_en = 1'b0;

        // randomized strobe/read sequences
        for (int t = 0; t < 40; t++) begin
            rand_btns();
            wr_strobe(1'b1);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                rand_btns();
                lv = nes_byte(udlr_dpad, abxy_btns, st_sel_hm_btns, 1'b1, 1'b1);
                lv_alt = nes_byte(udlr_dpad, abxy_btns, st_sel_hm_btns, 1'b0, 1'b0);
                rd_en = 1'($urandom);
                #2;
                check_eq("rnd_high_bit", rd_data[0], lv[0]);
                check_eq("rnd_high_bit_alt", rd_data_alt[0], lv_alt[0]);
                tick();
                rd_en = 1'b0;
                check_eq("rnd_high_bits_read", bits_read, 4'd0);
                check_eq("rnd_high_latched", latched_btns, lv);
            end
            rand_btns();
            snap = nes_byte(udlr_dpad, abxy_btns, st_sel_hm_btns, 1'b1, 1'b1);
            snap_alt = nes_byte(udlr_dpad, abxy_btns, st_sel_hm_btns, 1'b0, 1'b0);
            wr_strobe(1'b0);
            check_eq("rnd_latched", latched_btns, snap);
            check_eq("rnd_latched_alt", latched_alt, snap_alt);
            for (int n = 0; n < int'($urandom_range(0, 11)); n++) begin
                repeat ($urandom_range(0, 2)) begin
                    rand_btns();
                    tick();
                end
                rand_btns();
                read_bit("rnd_read", snap, snap_alt, n);
                check_eq("rnd_bits_read", bits_read, (n + 1 > 8) ? 8 : n + 1);
            end
        end

        // turbo on ZL with A released, strobe held high
        udlr_dpad = 4'h0; abxy_btns = 4'h0; st_sel_hm_btns = 3'b000; lr_z_btns = 2'b10;
        wr_strobe(1'b1);
        tick();
        for (int i = 0; i < 24; i++) begin
            #2;
            s_turbo[i] = rd_data[0];
            tick();
        end
`ifdef TURBO_EN
        first = -1;
        for (int i = 1; i < 9; i++)
            if (first < 0 && s_turbo[i] != s_turbo[i-1]) first = i;
        check_eq("turbo_toggle_seen", first >= 0, 1'b1);
        if (first >= 0)
            for (int j = first; j < 24; j++)
                check_eq("turbo_phase", s_turbo[j], s_turbo[first] ^ 1'(((j - first) / 4) % 2));
`else
        first = 0;
        for (int i = 0; i < 24; i++) check_eq("turbo_disabled", s_turbo[i], 1'b0);
`endif
        lr_z_btns = 2'b00;
        wr_strobe(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
